seq_sub_divider: RTL and testbench

Sequential unsigned divider that computes quotient and remainder by repeated subtraction, one subtract per clock. It is the inverse of the team's sequential accumulator: it counts subtractions of a divisor instead of accumulating additions. A start/busy/done handshake frames each operation. Intended as a datapath building block alongside the 8-bit adder/register library.

---
 rtl/seq_sub_divider.sv | 122 ++++++++++++
 tb/tb_seq_sub_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_sub_divider.sv
// seq_sub_divider: sequential unsigned divider using repeated subtraction,
// one subtract per clock, framed by a start/busy/done handshake.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   start        request a division; accepted only when not busy
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   quotient     result quotient, valid while done=1
//   remainder    result remainder, valid while done=1
//   busy         high while the division is running
//   done         high from completion until the next accepted start
//   div_by_zero  high with done when the captured divisor was 0
module seq_sub_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dvsr_nxt;
  logic             w_dbz_nxt;
  logic             w_accept;

  // start is only honoured outside RUN
  assign w_accept = start && (r_state != S_RUN);

  // State register and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_quot  <= w_quot_nxt;
      r_rem   <= w_rem_nxt;
      r_dvsr  <= w_dvsr_nxt;
      r_dbz   <= w_dbz_nxt;
      // busy/done are registered copies of the next-state decode
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_nxt = r_state;
    w_quot_nxt  = r_quot;
    w_rem_nxt   = r_rem;
    w_dvsr_nxt  = r_dvsr;
    w_dbz_nxt   = r_dbz;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_rem_nxt  = dividend;
          w_dvsr_nxt = divisor;
          if (divisor == '0) begin
            // Divide by zero finishes immediately with an all-ones quotient
            w_state_nxt = S_DONE;
            w_quot_nxt  = '1;
            w_dbz_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_quot_nxt  = '0;
            w_dbz_nxt   = 1'b0;
          end
        end
      end
      S_RUN: begin
        // Subtraction only when it cannot underflow
        if (r_rem >= r_dvsr) begin
          w_rem_nxt  = r_rem - r_dvsr;
          w_quot_nxt = r_quot + WIDTH'(1);
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_sub_divider.sv
// Self-checking bench for seq_sub_divider: directed cases plus random operands
// against a divide/modulo model, with a scoreboard of expected results.
module tb_seq_sub_divider;

  localparam int unsigned W     = 8;
  localparam int unsigned LIMIT = 600;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           busy_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  seq_sub_divider #(.WIDTH(W)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: push the expected outcome when the operation is issued
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1; e.busy_cyc = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      e.lat = int'(a / b) + 2; e.busy_cyc = int'(a / b) + 1;
    end
    sb.push_back(e);
  endtask

  // Issue one division, wait for done, compare against the scoreboard head.
  // hold_start keeps start high with scrambled operands during RUN.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start);
    exp_t e;
    int   lat;
    int   bcyc;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    lat  = 1;
    bcyc = 0;
    @(negedge clk);
    if (b != '0) begin
      check("dbz_clear", 32'(div_by_zero), 32'd0);
      check("done_clear", 32'(done), 32'd0);
    end
    while (!done && lat < LIMIT) begin
      if (busy) bcyc++;
      if (hold_start) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom_range(1, 255));
      end else begin
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check("timeout", 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("quotient", 32'(quotient), 32'(e.q));
      check("remainder", 32'(remainder), 32'(e.r));
      check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      check("latency", 32'(lat), 32'(e.lat));
      check("busy_cycles", 32'(bcyc), 32'(e.busy_cyc));
      check("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    n_checks = 0;
    n_errors = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset abandons a running operation without waiting for an edge
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_q", 32'(quotient), 32'd0);
    check("arst_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 100/7 with results held afterwards
    run_div(8'd100, 8'd7, 1'b0);
    hq = quotient; hr = remainder;
    repeat (5) @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    check("hold_q", 32'(quotient), 32'd14);
    check("hold_r", 32'(remainder), 32'd2);
    check("hold_q_same", 32'(quotient), 32'(hq));
    check("hold_r_same", 32'(remainder), 32'(hr));

    run_div(8'd5, 8'd9, 1'b0);
    run_div(8'd255, 8'd1, 1'b0);
    run_div(8'd255, 8'd1, 1'b1);
    run_div(8'd200, 8'd3, 1'b1);

    // Divide by zero, then straight from DONE into a normal division
    run_div(8'd42, 8'd0, 1'b0);
    run_div(8'd48, 8'd6, 1'b0);
    run_div(8'd0, 8'd0, 1'b0);
    run_div(8'd0, 8'd5, 1'b0);
    run_div(8'd7, 8'd7, 1'b0);
    run_div(8'd255, 8'd255, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = (i % 8 == 7) ? W'(0) : W'($urandom_range(1, 255));
      run_div(a, b, (i % 5 == 0));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
